// File: rtl/inst_assembler_pkg.sv
// Shared immediate-format codes (common with the core's extender) and a
// range helper used when packing immediates back into instruction words.
package inst_assembler_pkg;

  localparam logic [2:0] I_TYPE = 3'b000;
  localparam logic [2:0] S_TYPE = 3'b001;
  localparam logic [2:0] B_TYPE = 3'b010;
  localparam logic [2:0] J_TYPE = 3'b011;
  localparam logic [2:0] U_TYPE = 3'b100;
  localparam logic [2:0] R_TYPE = 3'b101;

  // True when value[31:lsb] are all copies of one bit, i.e. the value is a
  // correctly sign-extended field of width lsb+1.
  function automatic logic upperBitsEqual(input logic [31:0] value, input int unsigned lsb);
    logic [31:0] shifted;
    shifted = 32'($signed(value) >>> lsb);
    return (shifted == '0) || (shifted == '1);
  endfunction

endpackage

// File: rtl/inst_assembler_imm_pack.sv
// Combinational RV32I encoder: scatters the immediate into its format's bit
// positions and flags immediates that would not survive the extender.
module imm_pack
  import inst_assembler_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] inst_o,
  output logic        range_ok_o
);

  always_comb begin
    inst_o     = {25'b0, opcode_i};
    range_ok_o = 1'b0;
    case (imm_src_i)
      I_TYPE: begin
        inst_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        range_ok_o = upperBitsEqual(imm_i, 11);
      end
      S_TYPE: begin
        inst_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        range_ok_o = upperBitsEqual(imm_i, 11);
      end
      B_TYPE: begin
        inst_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
        range_ok_o = !imm_i[0] && upperBitsEqual(imm_i, 12);
      end
      J_TYPE: begin
        inst_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        range_ok_o = !imm_i[0] && upperBitsEqual(imm_i, 20);
      end
      U_TYPE: begin
        // U immediates arrive right-aligned, as the extender reports them.
        inst_o     = {imm_i[19:0], rd_i, opcode_i};
        range_ok_o = upperBitsEqual(imm_i, 19);
      end
      R_TYPE: begin
        inst_o     = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        range_ok_o = 1'b1;
      end
      default: begin
        inst_o     = {25'b0, opcode_i};
        range_ok_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_assembler.sv
// Sequential instruction assembler: packs requests into RV32I words and
// streams them as consecutive word writes starting at a base address.
module inst_assembler
  import inst_assembler_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       imm_src_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_addr_o,
  output logic [31:0]      out_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_count_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [ERR_W-1:0] ErrOne = ERR_W'(1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             outValid_q, outValid_d;
  logic [31:0]      outAddr_q, outAddr_d;
  logic [31:0]      outData_q, outData_d;
  logic             errPulse_q, errPulse_d;
  logic [ERR_W-1:0] errCount_q, errCount_d;

  logic [31:0] packedInst;
  logic        rangeOk;
  logic        accept;

  imm_pack u_imm_pack (
    .imm_src_i  (imm_src_i),
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .funct7_i   (funct7_i),
    .rd_i       (rd_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .imm_i      (imm_i),
    .inst_o     (packedInst),
    .range_ok_o (rangeOk)
  );

  // The output register may drain and refill in the same cycle.
  assign in_ready_o = (state_q == RUN) && (!outValid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    outValid_d  = outValid_q && !out_ready_i;
    outAddr_d   = outAddr_q;
    outData_d   = outData_q;
    errPulse_d  = accept && !rangeOk;
    errCount_d  = errCount_q;
    if (accept && !rangeOk && (errCount_q != '1)) begin
      errCount_d = errCount_q + ErrOne;
    end
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i & ~32'd3;
          remaining_d = count_i;
          state_d     = (count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && rangeOk) begin
          outValid_d  = 1'b1;
          outAddr_d   = addr_q;
          outData_d   = packedInst;
          addr_d      = addr_q + 32'd4;
          remaining_d = remaining_q - CntOne;
          if (remaining_q == CntOne) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!outValid_q || out_ready_i) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      outValid_q  <= 1'b0;
      outAddr_q   <= '0;
      outData_q   <= '0;
      errPulse_q  <= 1'b0;
      errCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      outValid_q  <= outValid_d;
      outAddr_q   <= outAddr_d;
      outData_q   <= outData_d;
      errPulse_q  <= errPulse_d;
      errCount_q  <= errCount_d;
    end
  end

  assign out_valid_o = outValid_q;
  assign out_addr_o  = outAddr_q;
  assign out_data_o  = outData_q;
  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign err_pulse_o = errPulse_q;
  assign err_count_o = errCount_q;

endmodule

// File: tb/tb_inst_assembler.sv
// Directed-vector bench for inst_assembler: checks packing, addressing,
// rejection, backpressure, zero-count, address wrap and mid-run reset.
module tb_inst_assembler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] count_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  imm_src_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [4:0]  rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_addr_o;
  logic [31:0] out_data_o;
  logic        busy_o;
  logic        done_o;
  logic        err_pulse_o;
  logic [7:0]  err_count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int cycle = 0;
  int doneCount = 0;
  int errPulseCount = 0;
  int lastHsCycle = -10;
  int lastDoneCycle = -10;
  int expDone = 0;

  inst_assembler #(.CNT_W(16), .ERR_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .count_i     (count_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .imm_src_i   (imm_src_i),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .rd_i        (rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .imm_i       (imm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_pulse_o (err_pulse_o),
    .err_count_o (err_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Observe handshakes and pulses mid-cycle, away from the active edge.
  always @(negedge clk_i) begin
    cycle++;
    if (out_valid_o && out_ready_i) begin
      wrAddr.push_back(out_addr_o);
      wrData.push_back(out_data_o);
      lastHsCycle = cycle;
    end
    if (done_o) begin
      doneCount++;
      lastDoneCycle = cycle;
    end
    if (err_pulse_o) errPulseCount++;
  end

  // Reference extender: recovers the immediate a decoder would see.
  function automatic logic [31:0] extendImm(input logic [2:0] src, input logic [31:0] w);
    case (src)
      3'b000:  return {{20{w[31]}}, w[31:20]};
      3'b001:  return {{20{w[31]}}, w[31:25], w[11:7]};
      3'b010:  return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'b011:  return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'b100:  return {{12{w[31]}}, w[31:12]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] addrAt(input int i);
    return (i < wrAddr.size()) ? wrAddr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] dataAt(input int i);
    return (i < wrData.size()) ? wrData[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic startRun(input logic [31:0] base, input logic [15:0] cnt);
    base_addr_i = base;
    count_i     = cnt;
    start_i     = 1'b1;
    @(posedge clk_i); #1;
    start_i     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] src, input logic [6:0] opc, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] imm);
    int waitCycles;
    imm_src_i  = src;
    opcode_i   = opc;
    funct3_i   = f3;
    funct7_i   = f7;
    rd_i       = rd;
    rs1_i      = rs1;
    rs2_i      = rs2;
    imm_i      = imm;
    in_valid_i = 1'b1;
    waitCycles = 0;
    @(negedge clk_i);
    while (!in_ready_o && waitCycles < 50) begin
      @(negedge clk_i);
      waitCycles++;
    end
    if (!in_ready_o) checkOutput("acceptTimeout", {31'b0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 60) begin
      @(posedge clk_i); #1;
      n++;
    end
    checkOutput("doneReached", doneCount, target);
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hiCount;
    int doneBefore;
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; count_i = '0; in_valid_i = 1'b0;
    imm_src_i = '0; opcode_i = '0; funct3_i = '0; funct7_i = '0; rd_i = '0; rs1_i = '0;
    rs2_i = '0; imm_i = '0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rstOutValid", {31'b0, out_valid_o}, 32'd0);
    checkOutput("rstOutAddr", out_addr_o, 32'd0);
    checkOutput("rstOutData", out_data_o, 32'd0);
    checkOutput("rstBusy", {31'b0, busy_o}, 32'd0);
    checkOutput("rstDone", {31'b0, done_o}, 32'd0);
    checkOutput("rstErrPulse", {31'b0, err_pulse_o}, 32'd0);
    checkOutput("rstErrCount", {24'b0, err_count_o}, 32'd0);
    checkOutput("rstInReady", {31'b0, in_ready_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    $display("[TB] single I-type word");
    clearLog();
    startRun(32'h100, 16'd1);
    checkOutput("runBusy", {31'b0, busy_o}, 32'd1);
    applyStimulus(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFB);
    expDone++;
    waitDone(expDone);
    checkOutput("t1Writes", wrAddr.size(), 32'd1);
    checkOutput("t1Addr", addrAt(0), 32'h100);
    checkOutput("t1Data", dataAt(0), 32'hFFB0_0093);
    checkOutput("t1RoundTrip", extendImm(3'b000, dataAt(0)), 32'hFFFF_FFFB);
    checkOutput("t1DoneLatency", lastDoneCycle, lastHsCycle + 1);
    @(posedge clk_i); #1;
    checkOutput("t1BusyAfter", {31'b0, busy_o}, 32'd0);
    checkOutput("t1DonePulse", {31'b0, done_o}, 32'd0);

    $display("[TB] S/B/J/U/R words, unaligned base");
    clearLog();
    startRun(32'h502, 16'd5);
    applyStimulus(3'b001, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'd8);
    applyStimulus(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    applyStimulus(3'b011, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    applyStimulus(3'b100, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0001_2345);
    applyStimulus(3'b101, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF);
    expDone++;
    waitDone(expDone);
    checkOutput("t2Writes", wrAddr.size(), 32'd5);
    checkOutput("t2DataS", dataAt(0), 32'h0051_2423);
    checkOutput("t2DataB", dataAt(1), 32'hFE00_0EE3);
    checkOutput("t2DataJ", dataAt(2), 32'h0010_00EF);
    checkOutput("t2DataU", dataAt(3), 32'h1234_52B7);
    checkOutput("t2DataR", dataAt(4), 32'h4031_00B3);
    checkOutput("t2RtS", extendImm(3'b001, dataAt(0)), 32'd8);
    checkOutput("t2RtB", extendImm(3'b010, dataAt(1)), 32'hFFFF_FFFC);
    checkOutput("t2RtJ", extendImm(3'b011, dataAt(2)), 32'h800);
    checkOutput("t2RtU", extendImm(3'b100, dataAt(3)), 32'h0001_2345);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2Addr%0d", i), addrAt(i), 32'h500 + 32'(4 * i));
    end

    $display("[TB] rejected requests");
    clearLog();
    errPulseCount = 0;
    startRun(32'h300, 16'd1);
    applyStimulus(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    applyStimulus(3'b010, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5);
    applyStimulus(3'b111, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("t3ErrPulses", errPulseCount, 32'd3);
    checkOutput("t3ErrCount", {24'b0, err_count_o}, 32'd3);
    checkOutput("t3NoWrites", wrAddr.size(), 32'd0);
    checkOutput("t3StillBusy", {31'b0, busy_o}, 32'd1);
    applyStimulus(3'b000, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 32'h7FF);
    expDone++;
    waitDone(expDone);
    checkOutput("t3Writes", wrAddr.size(), 32'd1);
    checkOutput("t3AddrKept", addrAt(0), 32'h300);
    checkOutput("t3Data", dataAt(0), 32'h7FF1_8113);

    $display("[TB] backpressure");
    clearLog();
    out_ready_i = 1'b0;
    startRun(32'h100, 16'd3);
    applyStimulus(3'b101, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    fork
      applyStimulus(3'b101, 7'h33, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0);
      begin
        hiCount = 0;
        repeat (5) begin
          @(negedge clk_i);
          if (in_ready_o) hiCount++;
        end
        checkOutput("t4InReadyFull", hiCount, 32'd0);
        checkOutput("t4HeldData", out_data_o, 32'h0000_00B3);
        checkOutput("t4HeldValid", {31'b0, out_valid_o}, 32'd1);
        @(posedge clk_i); #1;
        out_ready_i = 1'b1;
      end
    join
    applyStimulus(3'b101, 7'h33, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd0);
    expDone++;
    waitDone(expDone);
    checkOutput("t4Writes", wrAddr.size(), 32'd3);
    checkOutput("t4Addr0", addrAt(0), 32'h100);
    checkOutput("t4Addr1", addrAt(1), 32'h104);
    checkOutput("t4Addr2", addrAt(2), 32'h108);
    checkOutput("t4Data0", dataAt(0), 32'h0000_00B3);
    checkOutput("t4Data1", dataAt(1), 32'h0000_0133);
    checkOutput("t4Data2", dataAt(2), 32'h0000_01B3);
    checkOutput("t4DoneLatency", lastDoneCycle, lastHsCycle + 1);
    @(posedge clk_i); #1;
    checkOutput("t4BusyAfter", {31'b0, busy_o}, 32'd0);

    $display("[TB] zero count and address wrap");
    clearLog();
    startRun(32'h400, 16'd0);
    checkOutput("t5ZeroDone", {31'b0, done_o}, 32'd1);
    checkOutput("t5ZeroBusy", {31'b0, busy_o}, 32'd0);
    @(posedge clk_i); #1;
    expDone++;
    checkOutput("t5ZeroDoneEnd", {31'b0, done_o}, 32'd0);
    checkOutput("t5ZeroNoWrites", wrAddr.size(), 32'd0);
    startRun(32'hFFFF_FFFC, 16'd2);
    applyStimulus(3'b101, 7'h33, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd0);
    applyStimulus(3'b101, 7'h33, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd0);
    expDone++;
    waitDone(expDone);
    checkOutput("t5WrapAddr0", addrAt(0), 32'hFFFF_FFFC);
    checkOutput("t5WrapAddr1", addrAt(1), 32'h0000_0000);

    $display("[TB] reset with word pending");
    clearLog();
    out_ready_i = 1'b0;
    startRun(32'h100, 16'd2);
    applyStimulus(3'b101, 7'h33, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    checkOutput("t6Pending", {31'b0, out_valid_o}, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("t6RstOutValid", {31'b0, out_valid_o}, 32'd0);
    checkOutput("t6RstOutAddr", out_addr_o, 32'd0);
    checkOutput("t6RstOutData", out_data_o, 32'd0);
    checkOutput("t6RstBusy", {31'b0, busy_o}, 32'd0);
    checkOutput("t6RstInReady", {31'b0, in_ready_o}, 32'd0);
    checkOutput("t6RstErrCount", {24'b0, err_count_o}, 32'd0);
    rst_i = 1'b0;
    doneBefore = doneCount;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("t6NoDone", doneCount, doneBefore);
    checkOutput("t6NoWrites", wrAddr.size(), 32'd0);
    out_ready_i = 1'b1;
    startRun(32'h600, 16'd1);
    applyStimulus(3'b000, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    expDone++;
    waitDone(expDone);
    checkOutput("t6RestartAddr", addrAt(0), 32'h600);
    checkOutput("t6RestartData", dataAt(0), 32'h0010_0093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
